// File: rtl/pool_relu2.sv
// pool_relu2: ReLU + 2x2 stride-2 max pooling behind the convolution PE.
// Takes raster-order conv results and pairs columns horizontally. Even rows
// park their column-pair maxima in a line buffer. Odd rows combine with that
// buffer and push the ReLU'd value into a small output FIFO.
// Ports:
//   clk, n_reset        - clock, synchronous active-low reset
//   start               - frame enable, held high for the whole frame
//   conv_data/valid     - conv PE result pulse
//   ready_pool          - PE may accumulate (keeps one FIFO slot free)
//   pool_data/valid     - FIFO head, non-empty flag
//   pool_ready          - downstream pop request
//   frame_done          - every pooled output of the frame has been pushed
//   overflow            - sticky: push attempted into a full FIFO
module pool_relu2 #(
  parameter int unsigned FMAP_W     = 26,
  parameter int unsigned FMAP_H     = 26,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic signed [15:0] conv_data,
  input  logic               conv_valid,
  output logic               ready_pool,
  output logic signed [15:0] pool_data,
  output logic               pool_valid,
  input  logic               pool_ready,
  output logic               frame_done,
  output logic               overflow
);

  localparam int unsigned COL_W = $clog2(FMAP_W);
  localparam int unsigned ROW_W = $clog2(FMAP_H);
  localparam int unsigned LB_N  = FMAP_W / 2;
  localparam int unsigned LB_W  = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic signed [15:0]  r_pair;
  logic                r_frame_done;
  logic signed [15:0]  r_lbuf [LB_N];
  logic signed [15:0]  r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;

  logic                w_active;
  logic                w_accept;
  logic [LB_W-1:0]     w_lb_idx;
  logic signed [15:0]  w_hmax;
  logic signed [15:0]  w_vmax;
  logic signed [15:0]  w_relu;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Datapath: horizontal pair max, vertical max against line buffer, ReLU
  assign w_active  = (r_state == S_EVEN) || (r_state == S_ODD);
  assign w_accept  = w_active && start && conv_valid;
  assign w_lb_idx  = LB_W'(r_col >> 1);
  assign w_hmax    = (r_pair > conv_data) ? r_pair : conv_data;
  assign w_vmax    = (w_hmax > r_lbuf[w_lb_idx]) ? w_hmax : r_lbuf[w_lb_idx];
  assign w_relu    = (w_vmax > 16'sd0) ? w_vmax : 16'sd0;

  // FIFO handshake; a full FIFO still takes a push when a pop frees the slot
  assign pool_valid = (r_count != '0);
  assign pool_data  = pool_valid ? r_fifo[r_rd_ptr] : 16'sd0;
  assign w_pop      = pool_valid && pool_ready;
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push     = w_accept && (r_state == S_ODD) && r_col[0];
  assign w_do_push  = w_push && (!w_full || w_pop);

  // One slot stays free for the result already in flight in the PE
  assign ready_pool = (r_count <= CNT_W'(FIFO_DEPTH - 2)) && w_active;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

  // Frame FSM with raster counters and the horizontal pair register
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_pair       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_EVEN;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_EVEN, S_ODD: begin
          if (!start) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_pair  <= '0;
          end else if (conv_valid) begin
            if (!r_col[0]) r_pair <= conv_data;
            if (r_col == COL_W'(FMAP_W - 1)) begin
              r_col <= '0;
              if (r_row == ROW_W'(FMAP_H - 1)) begin
                r_row        <= '0;
                r_state      <= S_DONE;
                r_frame_done <= 1'b1;
              end else begin
                r_row   <= r_row + ROW_W'(1);
                r_state <= r_row[0] ? S_EVEN : S_ODD;
              end
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        S_DONE: begin
          if (!start) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
            r_pair       <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line buffer: contents need no reset, every even row rewrites them
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == S_EVEN) && r_col[0]) r_lbuf[w_lb_idx] <= w_hmax;
  end

  // FIFO storage; validity is carried by r_count alone
  always_ff @(posedge clk) begin
    if (w_do_push) r_fifo[r_wr_ptr] <= w_relu;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pool_relu2.sv
// Directed bench for pool_relu2: three instances (4x4, 6x6, 5x5) share one
// stimulus stream; each scenario resets all and checks only its instance.
module tb_pool_relu2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               n_reset;
  logic               start;
  logic signed [15:0] conv_data;
  logic               conv_valid;
  logic               pool_ready;

  logic               a_ready, a_valid, a_done, a_ovf;
  logic signed [15:0] a_data;
  logic               b_ready, b_valid, b_done, b_ovf;
  logic signed [15:0] b_data;
  logic               c_ready, c_valid, c_done, c_ovf;
  logic signed [15:0] c_data;

  pool_relu2 #(.FMAP_W(4), .FMAP_H(4), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .n_reset(n_reset), .start(start), .conv_data(conv_data),
    .conv_valid(conv_valid), .ready_pool(a_ready), .pool_data(a_data),
    .pool_valid(a_valid), .pool_ready(pool_ready), .frame_done(a_done),
    .overflow(a_ovf));

  pool_relu2 #(.FMAP_W(6), .FMAP_H(6), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .n_reset(n_reset), .start(start), .conv_data(conv_data),
    .conv_valid(conv_valid), .ready_pool(b_ready), .pool_data(b_data),
    .pool_valid(b_valid), .pool_ready(pool_ready), .frame_done(b_done),
    .overflow(b_ovf));

  pool_relu2 #(.FMAP_W(5), .FMAP_H(5), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .n_reset(n_reset), .start(start), .conv_data(conv_data),
    .conv_valid(conv_valid), .ready_pool(c_ready), .pool_data(c_data),
    .pool_valid(c_valid), .pool_ready(pool_ready), .frame_done(c_done),
    .overflow(c_ovf));

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int basic     [16] = '{1, 5, 2, 3, 4, 0, 7, 1, -3, -8, 9, 9, -1, -2, 10, 2};
  int exp_basic [4]  = '{5, 7, 0, 10};
  int exp_bp    [4]  = '{8, 10, 12, 20};
  int exp_odd   [4]  = '{7, 9, 17, 19};

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d);
    conv_data  = 16'(d);
    conv_valid = 1'b1;
    tick();
    conv_valid = 1'b0;
  endtask

  task automatic do_reset();
    n_reset    = 1'b0;
    start      = 1'b0;
    conv_valid = 1'b0;
    pool_ready = 1'b1;
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  // Full 4x4 basic frame on instance A with pool_ready=1; head checked per push
  task automatic run_basic(input string tag);
    int k;
    k = 0;
    start = 1'b1;
    tick();
    chk({tag, "_ready_start"}, 32'(a_ready), 1);
    for (int i = 0; i < 16; i++) begin
      pulse(basic[i]);
      if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
        chk({tag, "_push_valid"}, 32'(a_valid), 1);
        chk({tag, "_push_data"}, 32'(a_data), exp_basic[k]);
        k++;
      end
      if (i == 14) chk({tag, "_done_early"}, 32'(a_done), 0);
    end
    chk({tag, "_done"}, 32'(a_done), 1);
    chk({tag, "_ready_done"}, 32'(a_ready), 0);
    tick();
    chk({tag, "_drained"}, 32'(a_valid), 0);
    chk({tag, "_done_hold"}, 32'(a_done), 1);
    start = 1'b0;
    tick();
    chk({tag, "_done_clear"}, 32'(a_done), 0);
  endtask

  initial begin
    n_reset    = 1'b0;
    start      = 1'b0;
    conv_valid = 1'b0;
    conv_data  = '0;
    pool_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_data",  32'(a_data),  0);
    chk("rst_done",  32'(a_done),  0);
    chk("rst_ovf",   32'(a_ovf),   0);
    n_reset = 1'b1;
    tick();
    chk("idle_ready", 32'(a_ready), 0);

    // Basic 4x4 frame
    run_basic("basic");

    // ReLU clamps an all-negative frame to zero
    do_reset();
    start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      pulse(-100);
      if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
        chk("relu_valid", 32'(a_valid), 1);
        chk("relu_data", 32'(a_data), 0);
      end
    end
    chk("relu_ovf", 32'(a_ovf), 0);

    // Back-pressure and overflow on the 6x6 instance
    do_reset();
    pool_ready = 1'b0;
    start      = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) begin
      pulse((i / 6) * 6 + (i % 6) + 1);
      if (i == 7)  chk("bp_ready_cnt1", 32'(b_ready), 1);
      if (i == 9)  chk("bp_ready_cnt2", 32'(b_ready), 1);
      if (i == 11) chk("bp_ready_cnt3", 32'(b_ready), 0);
      if (i == 19) chk("bp_ovf_full", 32'(b_ovf), 0);
      if (i == 21) chk("bp_ovf_set", 32'(b_ovf), 1);
    end
    pool_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_drain_valid", 32'(b_valid), 1);
      chk("bp_drain_data", 32'(b_data), exp_bp[j]);
      tick();
    end
    chk("bp_empty", 32'(b_valid), 0);
    chk("bp_ovf_sticky", 32'(b_ovf), 1);

    // Odd dimensions: column 4 and row 4 never reach the output
    do_reset();
    pool_ready = 1'b0;
    start      = 1'b1;
    tick();
    for (int i = 0; i < 25; i++) begin
      if ((i / 5 == 4) || (i % 5 == 4)) pulse(32767);
      else pulse((i / 5) * 5 + (i % 5) + 1);
      if (i == 23) chk("odd_done_early", 32'(c_done), 0);
    end
    chk("odd_done", 32'(c_done), 1);
    chk("odd_ovf", 32'(c_ovf), 0);
    pool_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("odd_drain_valid", 32'(c_valid), 1);
      chk("odd_drain_data", 32'(c_data), exp_odd[j]);
      tick();
    end
    chk("odd_empty", 32'(c_valid), 0);

    // Simultaneous push and pop at count 1
    do_reset();
    pool_ready = 1'b0;
    start      = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) pulse(basic[i]);
    chk("pp_first_valid", 32'(a_valid), 1);
    chk("pp_first_data", 32'(a_data), 5);
    pulse(basic[6]);
    pool_ready = 1'b1;
    pulse(basic[7]);
    chk("pp_valid", 32'(a_valid), 1);
    chk("pp_head", 32'(a_data), 7);
    pool_ready = 1'b0;
    tick();
    chk("pp_hold_head", 32'(a_data), 7);
    pool_ready = 1'b1;
    tick();
    chk("pp_count1", 32'(a_valid), 0);

    // Reset mid-frame, then a clean frame
    do_reset();
    pool_ready = 1'b0;
    start      = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) pulse(1000);
    chk("mid_pre_valid", 32'(a_valid), 1);
    n_reset = 1'b0;
    start   = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(a_valid), 0);
    chk("mid_rst_data",  32'(a_data),  0);
    chk("mid_rst_ready", 32'(a_ready), 0);
    chk("mid_rst_done",  32'(a_done),  0);
    chk("mid_rst_ovf",   32'(a_ovf),   0);
    n_reset    = 1'b1;
    pool_ready = 1'b1;
    tick();
    run_basic("mid");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pool_relu2.md
# pool_relu2

Downstream neighbour of the convolution PE. It consumes the PE's one-cycle result pulses (`conv_data`/`conv_valid`) in raster order and applies ReLU plus 2×2 stride-2 max pooling. Pooled results are emitted through a small output FIFO with a valid/ready handshake. It drives `ready_pool` back to the PE so that accumulation stalls before the FIFO can overflow.

## Interface
Parameters:
- `FMAP_W`, default 26: conv output columns per row (≥2).
- `FMAP_H`, default 26: conv output rows per frame (≥2).
- `FIFO_DEPTH`, default 4: output FIFO entries (≥2).

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `n_reset` input 1: synchronous, active-low reset.
- `start` input 1: frame enable; held high for the whole frame.
- `conv_data` input signed 16: conv PE result.
- `conv_valid` input 1: one-cycle pulse qualifying `conv_data`.
- `ready_pool` output 1: to conv PE; high means the PE may accumulate.
- `pool_data` output signed 16: pooled, ReLU'd value at the FIFO head.
- `pool_valid` output 1: FIFO non-empty.
- `pool_ready` input 1: downstream accepts `pool_data`.
- `frame_done` output 1: all pooled outputs of the frame have been pushed.
- `overflow` output 1: sticky error; a push was attempted into a full FIFO.

## Operation
States:
- IDLE: waits for `start`=1, then enters EVEN_ROW with `row`=0 and `col`=0.
- EVEN_ROW
- ODD_ROW
- DONE: `frame_done`=1. Leaves to IDLE when `start`=0.

Frame processing:
- `start`=0 in any non-IDLE state aborts the frame and returns to IDLE. Counters and the pair register clear. FIFO contents are kept.
- Each accepted `conv_valid` advances `col`. When `col`=FMAP_W-1, `col` wraps to 0 and `row` increments.
- Row parity selects EVEN_ROW or ODD_ROW. After the last sample of row FMAP_H-1, the state goes to DONE.
- `conv_valid` in IDLE or DONE is ignored.

Horizontal pairing:
- An even `col` stores the sample in the pair register.
- An odd `col` forms `hmax` = signed max(pair register, sample).
- If FMAP_W is odd, the final column of each row is discarded.

Even rows:
- `hmax` is written to line buffer entry `col>>1`. The buffer has FMAP_W/2 entries of 16 bits.

Odd rows:
- `v` = signed max(`hmax`, line buffer entry `col>>1`).
- ReLU: the pushed value is `v` if `v` > 0, else 0.
- If FMAP_H is odd, the final row is accepted but produces no pushes.

Output FIFO:
- `pool_valid` = (count ≠ 0). `pool_data` = head entry, or 0 when empty.
- A pop occurs when `pool_valid` && `pool_ready`.
- A push and a pop in the same cycle leave the count unchanged. Depth ordering is preserved.
- A push into a full FIFO (with no simultaneous pop) drops the data and sets `overflow`. Only reset clears `overflow`.

Back-pressure:
- `ready_pool` = (count ≤ FIFO_DEPTH-2) && state ∈ {EVEN_ROW, ODD_ROW}.
- The PE emits its result pulse regardless of `ready_pool`. The one-slot margin covers the single in-flight result.

Arithmetic: all compares are 16-bit signed; no widening.

Reset (synchronous, `n_reset`=0 at a clock edge):
- State goes to IDLE; `row`, `col`, pair register and FIFO count clear.
- Outputs: `ready_pool`=0, `pool_valid`=0, `pool_data`=0, `frame_done`=0, `overflow`=0.
- Line buffer contents are don't-care.
- Reset mid-frame discards everything in flight.

## Timing
- A push is registered: the pooled value appears at the FIFO head and `pool_valid` rises 1 cycle after the odd-row, odd-column `conv_valid` edge (if the FIFO was empty).
- `ready_pool` is combinational from the registered count and state. It falls in the same cycle the count reaches FIFO_DEPTH-1.
- `frame_done` rises 1 cycle after the last accepted `conv_valid` of the frame and holds until `start`=0.
- Throughput: one `conv_valid` accepted per cycle; back-to-back pulses are legal.
- One pop per cycle.

## Test plan
- **Basic 4×4 frame** (FMAP_W=FMAP_H=4), rows [1,5,2,3], [4,0,7,1], [-3,-8,9,9], [-1,-2,10,2], `pool_ready`=1 → pushes 5, 7, 0, 10 in order. `frame_done`=1 one cycle after the 16th pulse.
- **ReLU, all negative**: 4×4 frame of all -100 → four outputs of 0. `overflow`=0.
- **Back-pressure**: `pool_ready`=0, FIFO_DEPTH=4, 6×6 frame of positive data → `ready_pool` drops once the count reaches 3. After the 4th push the FIFO is full. A further pulse sets `overflow`=1 and the count stays 4. Raising `pool_ready` drains the 4 values in order.
- **Odd dimensions**: FMAP_W=5, FMAP_H=5 → exactly 4 outputs. Column 4 and row 4 values (set to 32767) never appear.
- **Simultaneous push/pop**: count=1 with a push and a pop in the same cycle → count stays 1, and the next head is the pushed value.
- **Reset mid-frame**: `n_reset`=0 after 7 pulses, then a fresh full 4×4 frame → all outputs are 0 during reset. The new frame produces the basic-frame results with no stale line-buffer effects.
